// File: rtl/clock_pkg.sv
// Shared definitions for the alarm-clock digit cells.
//   - digit modulus constants for the time/alarm fields
//   - cnt_op_e: the single operation a counter cell commits on an edge
package clock_pkg;

  localparam int SEC_UNITS_MOD = 10;
  localparam int SEC_TENS_MOD  = 6;
  localparam int HOUR24_MOD    = 24;
  localparam int HOUR12_MOD    = 12;

  typedef enum logic [2:0] {
    HOLD,
    CLR,
    LOAD,
    INC,
    DEC
  } cnt_op_e;

endpackage

// File: rtl/cnt_op_decode.sv
// Combinational control decode for a counter cell.
//   clr, load, inc, dec : raw per-edge controls
//   op                  : operation to commit, clr > load > inc/dec
// inc and dec together cancel to HOLD.
module cnt_op_decode
  import clock_pkg::*;
(
  input  logic    clr,
  input  logic    load,
  input  logic    inc,
  input  logic    dec,
  output cnt_op_e op
);

  always_comb begin
    op = HOLD;
    if (clr)              op = CLR;
    else if (load)        op = LOAD;
    else if (inc && !dec) op = INC;
    else if (dec && !inc) op = DEC;
  end

endmodule

// File: rtl/mod_counter_reg.sv
// Modulo-MODULUS up/down counter cell with clear, clamped load and
// cascade outputs.
//   clk, rst_n        : clock, async active-low reset
//   clr, load, D      : sync clear to RESET_VAL, sync load of D
//   inc, dec          : one step up/down (both high = hold)
//   Q                 : registered count, always in 0..MODULUS-1
//   carry, borrow     : this edge wraps up / down (feed next cell's inc/dec)
//   at_max, at_zero   : decode of current Q
//   load_err          : sticky, set by an out-of-range load, cleared by clr
module mod_counter_reg
  import clock_pkg::*;
#(
  parameter int WIDTH     = 4,
  parameter int MODULUS   = 10,
  parameter int RESET_VAL = 0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clr,
  input  logic             load,
  input  logic [WIDTH-1:0] D,
  input  logic             inc,
  input  logic             dec,
  output logic [WIDTH-1:0] Q,
  output logic             carry,
  output logic             borrow,
  output logic             at_max,
  output logic             at_zero,
  output logic             load_err
);

  generate
    if (MODULUS < 2 || MODULUS > (1 << WIDTH)) begin : g_bad_modulus
      $error("mod_counter_reg: MODULUS out of range 2..2^WIDTH");
    end
    if (RESET_VAL < 0 || RESET_VAL >= MODULUS) begin : g_bad_reset_val
      $error("mod_counter_reg: RESET_VAL must be < MODULUS");
    end
  endgenerate

  localparam int              WP1  = WIDTH + 1;
  localparam logic [WIDTH-1:0] QMAX = WIDTH'(MODULUS - 1);
  localparam logic [WIDTH-1:0] QRST = WIDTH'(RESET_VAL);
  localparam logic [WIDTH-1:0] ONE  = WIDTH'(1);
  // One extra bit so MODULUS = 2^WIDTH is representable; every D is then legal.
  localparam logic [WIDTH:0]   MODV = WP1'(MODULUS);

  cnt_op_e op;
  logic    d_ok;

  cnt_op_decode u_decode (
    .clr  (clr),
    .load (load),
    .inc  (inc),
    .dec  (dec),
    .op   (op)
  );

  assign d_ok    = ({1'b0, D} < MODV);
  assign at_max  = (Q == QMAX);
  assign at_zero = (Q == '0);
  // Wrap compare against QMAX, not against natural overflow, so Q stays
  // in range for any modulus.
  assign carry   = (op == INC) && at_max;
  assign borrow  = (op == DEC) && at_zero;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      Q        <= QRST;
      load_err <= 1'b0;
    end else begin
      unique case (op)
        CLR: begin
          Q        <= QRST;
          load_err <= 1'b0;
        end
        LOAD: begin
          Q <= d_ok ? D : QMAX;
          if (!d_ok) load_err <= 1'b1;
        end
        INC:     Q <= at_max  ? '0   : Q + ONE;
        DEC:     Q <= at_zero ? QMAX : Q - ONE;
        default: Q <= Q;
      endcase
    end
  end

endmodule

// File: tb/tb_mod_counter_reg.sv
// Directed bench for mod_counter_reg: table of single-edge vectors on a
// mod-10 cell, plus hand sequences for async reset, a mod-10 -> mod-6
// cascade, and a full-range mod-16 cell.
module tb_mod_counter_reg;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  int n_chk = 0;
  int n_fail = 0;

  task automatic chk(input string name, input int act, input int exp);
    n_chk++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // main mod-10 cell
  logic       clr = 0, load = 0, inc = 0, dec = 0;
  logic [3:0] d = 0, q;
  logic       carry, borrow, at_max, at_zero, err;

  mod_counter_reg #(.WIDTH(4), .MODULUS(10), .RESET_VAL(0)) dut (
    .clk(clk), .rst_n(rst_n), .clr(clr), .load(load), .D(d), .inc(inc),
    .dec(dec), .Q(q), .carry(carry), .borrow(borrow), .at_max(at_max),
    .at_zero(at_zero), .load_err(err)
  );

  // cascade: units (mod 10) carry -> tens (mod 6) inc
  logic       u_load = 0, u_inc = 0, t_load = 0;
  logic [3:0] u_d = 0, t_d = 0, uq, tq;
  logic       u_carry, u_borrow, u_amax, u_azero, u_err;
  logic       t_carry, t_borrow, t_amax, t_azero, t_err;

  mod_counter_reg #(.WIDTH(4), .MODULUS(10), .RESET_VAL(0)) u_units (
    .clk(clk), .rst_n(rst_n), .clr(1'b0), .load(u_load), .D(u_d), .inc(u_inc),
    .dec(1'b0), .Q(uq), .carry(u_carry), .borrow(u_borrow), .at_max(u_amax),
    .at_zero(u_azero), .load_err(u_err)
  );

  mod_counter_reg #(.WIDTH(4), .MODULUS(6), .RESET_VAL(0)) u_tens (
    .clk(clk), .rst_n(rst_n), .clr(1'b0), .load(t_load), .D(t_d), .inc(u_carry),
    .dec(1'b0), .Q(tq), .carry(t_carry), .borrow(t_borrow), .at_max(t_amax),
    .at_zero(t_azero), .load_err(t_err)
  );

  // full-range cell: MODULUS = 2^WIDTH
  logic       s_load = 0, s_inc = 0, s_dec = 0;
  logic [3:0] s_d = 0, sq;
  logic       s_carry, s_borrow, s_amax, s_azero, s_err;

  mod_counter_reg #(.WIDTH(4), .MODULUS(16), .RESET_VAL(0)) u_m16 (
    .clk(clk), .rst_n(rst_n), .clr(1'b0), .load(s_load), .D(s_d), .inc(s_inc),
    .dec(s_dec), .Q(sq), .carry(s_carry), .borrow(s_borrow), .at_max(s_amax),
    .at_zero(s_azero), .load_err(s_err)
  );

  typedef struct {
    logic       clr, load, inc, dec;
    logic [3:0] d;
    logic       e_carry, e_borrow;  // before the edge
    logic [3:0] e_q;                // after the edge
    logic       e_err;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(logic c, logic l, logic i, logic dd, logic [3:0] dv,
                              logic ec, logic eb, logic [3:0] eq, logic ee);
    vec_t v;
    v.clr = c; v.load = l; v.inc = i; v.dec = dd; v.d = dv;
    v.e_carry = ec; v.e_borrow = eb; v.e_q = eq; v.e_err = ee;
    return v;
  endfunction

  initial begin
    logic [3:0] pq;
    int tc, uc;

    // reset wrap-up: 1..9 then 9 -> 0 with carry
    for (int k = 1; k <= 9; k++) vecs.push_back(mk(0,0,1,0,0, 0,0, 4'(k), 0));
    vecs.push_back(mk(0,0,1,0,0,   1,0, 0, 0));
    vecs.push_back(mk(0,0,1,1,0,   0,0, 0, 0));  // inc&dec at 0: hold, no borrow
    vecs.push_back(mk(0,0,0,1,0,   0,1, 9, 0));  // wrap down
    vecs.push_back(mk(0,0,0,1,0,   0,0, 8, 0));
    vecs.push_back(mk(0,1,0,0,4'hC,0,0, 9, 1));  // clamp
    vecs.push_back(mk(0,1,0,0,3,   0,0, 3, 1));  // sticky
    vecs.push_back(mk(0,0,0,0,0,   0,0, 3, 1));
    vecs.push_back(mk(1,0,0,0,0,   0,0, 0, 0));
    vecs.push_back(mk(0,1,0,0,9,   0,0, 9, 0));  // MODULUS-1 is legal
    vecs.push_back(mk(0,1,0,0,10,  0,0, 9, 1));  // MODULUS is not
    vecs.push_back(mk(1,0,0,0,0,   0,0, 0, 0));
    vecs.push_back(mk(0,1,0,0,9,   0,0, 9, 0));
    vecs.push_back(mk(0,1,1,0,5,   0,0, 5, 0));  // load beats inc at max: no carry
    vecs.push_back(mk(0,0,1,1,0,   0,0, 5, 0));
    vecs.push_back(mk(1,1,1,0,5,   0,0, 0, 0));  // clr beats all
    vecs.push_back(mk(1,0,0,1,0,   0,0, 0, 0));  // clr masks borrow
    vecs.push_back(mk(0,1,0,1,2,   0,0, 2, 0));  // load masks dec
    vecs.push_back(mk(0,0,0,1,0,   0,0, 1, 0));
    vecs.push_back(mk(0,0,0,1,0,   0,0, 0, 0));
    vecs.push_back(mk(0,0,0,1,0,   0,1, 9, 0));

    // reset state
    #2;
    chk("reset_q", q, 0);
    chk("reset_err", err, 0);
    chk("reset_at_zero", at_zero, 1);
    @(negedge clk); rst_n = 1'b1;
    pq = 0;

    foreach (vecs[n]) begin
      @(negedge clk);
      clr = vecs[n].clr; load = vecs[n].load; inc = vecs[n].inc;
      dec = vecs[n].dec; d = vecs[n].d;
      #1;
      chk($sformatf("v%0d_carry", n), carry, vecs[n].e_carry);
      chk($sformatf("v%0d_borrow", n), borrow, vecs[n].e_borrow);
      chk($sformatf("v%0d_at_max", n), at_max, int'(pq == 9));
      chk($sformatf("v%0d_at_zero", n), at_zero, int'(pq == 0));
      @(posedge clk); #1;
      chk($sformatf("v%0d_q", n), q, vecs[n].e_q);
      chk($sformatf("v%0d_err", n), err, vecs[n].e_err);
      pq = vecs[n].e_q;
    end

    // async reset mid-count, with load_err set
    @(negedge clk); clr = 0; inc = 0; dec = 0; load = 1; d = 4'hC;
    @(negedge clk); d = 7;
    @(negedge clk); load = 0;
    chk("pre_rst_q", q, 7);
    chk("pre_rst_err", err, 1);
    #2 rst_n = 1'b0;
    #1;
    chk("async_rst_q", q, 0);
    chk("async_rst_err", err, 0);
    @(negedge clk); rst_n = 1'b1;
    @(posedge clk); #1;
    chk("post_rst_q", q, 0);

    // cascade: 59 -> 00 on one edge
    @(negedge clk); u_load = 1; u_d = 9; t_load = 1; t_d = 5;
    @(negedge clk); u_load = 0; t_load = 0;
    chk("casc_load_u", uq, 9);
    chk("casc_load_t", tq, 5);
    u_inc = 1;
    #1;
    chk("casc_u_carry", u_carry, 1);
    chk("casc_t_carry", t_carry, 1);
    @(posedge clk); #1;
    chk("casc_59_u", uq, 0);
    chk("casc_59_t", tq, 0);

    // 600 steps from 00
    tc = 0; uc = 0;
    for (int k = 0; k < 600; k++) begin
      @(negedge clk); #1;
      if (t_carry) tc++;
      if (u_carry) uc++;
    end
    @(negedge clk); u_inc = 0;
    chk("casc_600_u", uq, 0);
    chk("casc_600_t", tq, 0);
    chk("casc_600_tcarries", tc, 10);
    chk("casc_600_ucarries", uc, 60);

    // MODULUS = 2^WIDTH wraps both ways
    @(negedge clk); s_load = 1; s_d = 15;
    @(negedge clk); s_load = 0; s_inc = 1;
    #1;
    chk("m16_at_max", s_amax, 1);
    chk("m16_carry", s_carry, 1);
    @(posedge clk); #1;
    chk("m16_wrap_up", sq, 0);
    @(negedge clk); s_inc = 0; s_dec = 1;
    #1;
    chk("m16_borrow", s_borrow, 1);
    @(posedge clk); #1;
    chk("m16_wrap_down", sq, 15);
    chk("m16_err", s_err, 0);
    @(negedge clk); s_dec = 0;

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/mod_counter_reg.md
# mod_counter_reg

Parametrised modulo-N up/down counter register: successor to the 4-bit load/increment register, generalised in width and modulus. Adds decrement, synchronous clear, load-range clamping, and cascade outputs (carry/borrow). Serves as the digit cell for the alarm-clock time and alarm fields: seconds/minutes units (mod 10), tens (mod 6), hours (mod 24 or mod 12). Cells chain by feeding one cell's carry/borrow into the next cell's inc/dec on the same clock.

## Interface
- WIDTH, 4, counter width in bits
- MODULUS, 10, count range 0..MODULUS-1; legal range 2 ≤ MODULUS ≤ 2^WIDTH
- RESET_VAL, 0, value loaded by reset and clr; must be < MODULUS
- clk  in  1  clock; all state updates on rising edge
- rst_n  in  1  asynchronous, active-low reset
- clr  in  1  synchronous clear to RESET_VAL
- load  in  1  synchronous parallel load of D
- D  in  WIDTH  load value
- inc  in  1  count up one step
- dec  in  1  count down one step
- Q  out  WIDTH  current count, registered
- carry  out  1  combinational; this edge wraps MODULUS-1 → 0
- borrow  out  1  combinational; this edge wraps 0 → MODULUS-1
- at_max  out  1  combinational; Q == MODULUS-1
- at_zero  out  1  combinational; Q == 0
- load_err  out  1  registered sticky flag; out-of-range load occurred

## Operation
- Clock and reset: one clock (clk). Reset is asynchronous and active-low (rst_n).
- Reset values while rst_n = 0: Q = RESET_VAL, load_err = 0. Release takes effect at the next rising edge. Reset mid-count discards the count immediately.
- Per-edge priority, highest first:
  1. clr: Q ← RESET_VAL, load_err ← 0.
  2. load: Q ← D if D < MODULUS. Otherwise Q ← MODULUS-1 (clamp) and load_err ← 1.
  3. inc & dec both high: hold.
  4. inc alone: Q ← (Q == MODULUS-1) ? 0 : Q+1.
  5. dec alone: Q ← (Q == 0) ? MODULUS-1 : Q-1.
  6. None: hold.
- carry = inc & ~dec & ~load & ~clr & at_max.
- borrow = dec & ~inc & ~load & ~clr & at_zero.
- carry and borrow are never high together. Each is high only in a cycle where the matching wrap commits at the next edge.
- load_err stays set until clr or reset. Any later in-range load does not clear it.
- Arithmetic is in WIDTH bits. The wrap compare is against the MODULUS-1 constant, so Q never leaves 0..MODULUS-1, including when MODULUS = 2^WIDTH.

## Timing
- Q latency: 1 cycle from a sampled control to the updated Q.
- carry, borrow, at_max, at_zero: zero latency. They are a combinational decode of the current Q and current controls, with no path from D.
- Cascade: a lower cell's carry drives the upper cell's inc. Both cells update on the same edge, so a full ripple through k cells settles within one cycle. The combinational depth of that chain is the integrator's timing budget.
- A single inc pulse held for n cycles produces n steps. Edge detection of buttons is done upstream, not in this block.
- load_err rises on the edge that commits the clamped load.

## Structure
- Shared package `clock_pkg`:
  - digit modulus constants: SEC_UNITS_MOD = 10, SEC_TENS_MOD = 6, HOUR24_MOD = 24, HOUR12_MOD = 12
  - the `cnt_op_e` enum {HOLD, CLR, LOAD, INC, DEC}, used internally and by the bench for scoreboarding
- One sub-module is natural: `cnt_op_decode`. It is combinational; it maps clr/load/inc/dec to `cnt_op_e` by the priority above and is reused by the chained time-field wrapper.
- Parameter legality is checked with elaboration-time assertions: MODULUS range, RESET_VAL < MODULUS.

## Test plan
- Reset and wrap up: WIDTH = 4, MODULUS = 10, rst_n low, then inc for 10 cycles → Q steps 1..9, 0. carry is high only in the cycle Q = 9. at_zero is high after the wrap.
- Wrap down: Q = 0, dec for 2 cycles → Q = 9 then 8. borrow is high only in the first of those cycles.
- Load clamp: load with D = 4'hC, MODULUS = 10 → Q = 9, load_err = 1. A following load with D = 3 → Q = 3, load_err stays 1. clr → Q = 0, load_err = 0.
- Priority: clr = load = inc = 1 with D = 5 → Q = RESET_VAL. Then load = inc = 1 with D = 5 → Q = 5 and carry = 0. Then inc = dec = 1 → Q holds at 5.
- Async reset mid-count: Q = 7, drop rst_n between edges → Q = 0 before the next edge, and load_err clears.
- Cascade: a mod-10 cell's carry feeds a mod-6 cell's inc. From 59, one inc → 00 on a single edge. 600 incs from 00 → 00 with exactly 10 upper-cell carries.
